// File: rtl/vga_pixel_renderer.sv
// vga_pixel_renderer: pixel-colour stage behind the VGA timing tracker.
// Walks the cell grid in step with the visible area, reads each cell's
// content from the board RAM and produces registered 12-bit RGB, with the
// syncs delayed by the same three stages so they stay aligned to the pixels.
//
// Ports
//   clock_25     pixel clock
//   reset        asynchronous, active-low reset
//   display_area high while the current pixel is visible
//   h_sync_in    active-low horizontal sync from the tracker
//   v_sync_in    active-low vertical sync from the tracker
//   frame_tik    high during vertical sync
//   game_over    game-over flag, latched once per frame
//   cell_addr    board RAM read address (row*GRID_COLS+col)
//   cell_data    RAM read data, one cycle after cell_addr
//   red/green/blue  pixel colour
//   h_sync_out   h_sync_in delayed 3 cycles
//   v_sync_out   v_sync_in delayed 3 cycles
//   frame_start  one-cycle pulse at the start of vertical sync
`timescale 1ns/1ps
module vga_pixel_renderer #(
  parameter int CELL_SIZE  = 20,
  parameter int GRID_COLS  = 32,
  parameter int GRID_ROWS  = 24,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock_25,
  input  logic                  reset,
  input  logic                  display_area,
  input  logic                  h_sync_in,
  input  logic                  v_sync_in,
  input  logic                  frame_tik,
  input  logic                  game_over,
  output logic [ADDR_WIDTH-1:0] cell_addr,
  input  logic [1:0]            cell_data,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  h_sync_out,
  output logic                  v_sync_out,
  output logic                  frame_start
);

  localparam int STAGES = 3;
  localparam int PIX_W  = $clog2(CELL_SIZE);
  localparam int COL_W  = $clog2(GRID_COLS);
  localparam int ROW_W  = $clog2(GRID_ROWS);

  logic [PIX_W-1:0]    pix_cnt, line_cnt;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;

  // Stage-indexed pipelines; index k holds the value after k register stages.
  logic [STAGES-1:1]   vld_pipe;
  logic [STAGES-1:1]   brd_pipe;
  logic [STAGES:1]     hs_pipe, vs_pipe;

  logic                tik_q, go_latch;
  logic [11:0]         rgb;
  logic                eol, border;

  // End of line: display_area falling against its stage-1 copy.
  assign eol    = vld_pipe[1] & ~display_area;
  assign border = (row == '0) || (row == ROW_W'(GRID_ROWS-1)) ||
                  (col == '0) || (col == COL_W'(GRID_COLS-1));

  // Horizontal walk; col sticks at the last column on over-long lines.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      pix_cnt <= '0;
      col     <= '0;
    end else if (display_area) begin
      if (pix_cnt == PIX_W'(CELL_SIZE-1)) begin
        pix_cnt <= '0;
        if (col != COL_W'(GRID_COLS-1)) col <= col + 1'b1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end else begin
      pix_cnt <= '0;
      col     <= '0;
    end
  end

  // Vertical walk; frame_tik wins over an end-of-line in the same cycle.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      line_cnt <= '0;
      row      <= '0;
    end else if (frame_tik) begin
      line_cnt <= '0;
      row      <= '0;
    end else if (eol) begin
      if (line_cnt == PIX_W'(CELL_SIZE-1)) begin
        line_cnt <= '0;
        if (row != ROW_W'(GRID_ROWS-1)) row <= row + 1'b1;
      end else begin
        line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  // Stage 1: address plus the side-band that travels with the pixel.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      cell_addr <= '0;
      vld_pipe  <= '0;
      brd_pipe  <= '0;
      hs_pipe   <= '1;
      vs_pipe   <= '1;
    end else begin
      if (display_area)
        cell_addr <= ADDR_WIDTH'(row) * ADDR_WIDTH'(GRID_COLS) + ADDR_WIDTH'(col);
      vld_pipe <= {vld_pipe[STAGES-2:1], display_area};
      brd_pipe <= {brd_pipe[STAGES-2:1], border};
      hs_pipe  <= {hs_pipe[STAGES-1:1], h_sync_in};
      vs_pipe  <= {vs_pipe[STAGES-1:1], v_sync_in};
    end
  end

  // Frame tick edge detect. History resets high so a tick already in
  // progress at reset release does not produce a pulse.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      tik_q       <= 1'b1;
      frame_start <= 1'b0;
      go_latch    <= 1'b0;
    end else begin
      tik_q       <= frame_tik;
      frame_start <= frame_tik & ~tik_q;
      if (frame_start) go_latch <= game_over;
    end
  end

  // Stage 3: colour, with cell_data arriving from the RAM's own register.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      rgb <= 12'h000;
    end else if (!vld_pipe[STAGES-1]) begin
      rgb <= 12'h000;
    end else begin
      unique case (cell_data)
        2'b11:   rgb <= 12'hF00;
        2'b10:   rgb <= go_latch ? 12'hF0F : 12'h8FF & 12'h8F8;
        2'b01:   rgb <= go_latch ? 12'hF0F : 12'h0F0;
        default: rgb <= brd_pipe[STAGES-1] ? 12'h888 : 12'h000;
      endcase
    end
  end

  assign red        = rgb[11:8];
  assign green      = rgb[7:4];
  assign blue       = rgb[3:0];
  assign h_sync_out = hs_pipe[STAGES];
  assign v_sync_out = vs_pipe[STAGES];

endmodule

// File: tb/tb_vga_pixel_renderer.sv
`timescale 1ns/1ps
module tb_vga_pixel_renderer;

  localparam int CS = 20, GC = 32, GR = 24, AW = 10;
  localparam int NOBS = 65536;

  logic          clock_25 = 1'b0;
  logic          reset = 1'b0;
  logic          display_area = 1'b0, h_sync_in = 1'b1, v_sync_in = 1'b1;
  logic          frame_tik = 1'b1, game_over = 1'b0;
  logic [AW-1:0] cell_addr;
  logic [1:0]    cell_data;
  logic [3:0]    red, green, blue;
  logic          h_sync_out, v_sync_out, frame_start;

  always #20 clock_25 = ~clock_25;

  vga_pixel_renderer #(.CELL_SIZE(CS), .GRID_COLS(GC), .GRID_ROWS(GR), .ADDR_WIDTH(AW)) dut (
    .clock_25(clock_25), .reset(reset), .display_area(display_area),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .frame_tik(frame_tik),
    .game_over(game_over), .cell_addr(cell_addr), .cell_data(cell_data),
    .red(red), .green(green), .blue(blue), .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out), .frame_start(frame_start)
  );

  // Board RAM: registered read.
  logic [1:0] mem [0:1023];
  always @(posedge clock_25) cell_data <= mem[cell_addr];

  int n_chk = 0, n_pass = 0, sn = 0;
  logic [11:0]   obs_rgb  [0:NOBS-1];
  logic          obs_hs   [0:NOBS-1];
  logic          obs_fs   [0:NOBS-1];
  logic [AW-1:0] obs_addr [0:NOBS-1];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h want %0h", nm, sn, act, exp);
  endtask

  // Reference model: pixel position from plain arithmetic on counts of
  // visible cycles and end-of-line events; outputs via a 2-deep delay queue.
  int            m_x, m_eol;
  logic          m_pd, m_ptik, m_go;
  logic [13:0]   mq[$];
  logic [11:0]   p_rgb;
  logic          p_hs, p_vs, p_fs;
  logic [AW-1:0] p_addr;

  task automatic model_reset();
    m_x = 0; m_eol = 0; m_pd = 1'b0; m_ptik = 1'b1; m_go = 1'b0;
    mq.delete();
    mq.push_back({12'h000, 1'b1, 1'b1});
    mq.push_back({12'h000, 1'b1, 1'b1});
    p_rgb = 12'h000; p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0; p_addr = '0;
  endtask

  function automatic logic [11:0] colour(input logic [1:0] c, input logic b, input logic g);
    case (c)
      2'b11:   return 12'hF00;
      2'b10:   return g ? 12'hF0F : 12'h8F8;
      2'b01:   return g ? 12'hF0F : 12'h0F0;
      default: return b ? 12'h888 : 12'h000;
    endcase
  endfunction

  task automatic model_cycle(input logic d, input logic hs, input logic vs, input logic tik);
    int col, row, a;
    logic b;
    logic [11:0] px;
    logic [13:0] e;
    if (p_fs) m_go = game_over;
    col = m_x / CS;   if (col > GC-1) col = GC-1;
    row = m_eol / CS; if (row > GR-1) row = GR-1;
    a = row * GC + col;
    b = (row == 0) || (row == GR-1) || (col == 0) || (col == GC-1);
    px = d ? colour(mem[a], b, m_go) : 12'h000;
    mq.push_back({px, hs, vs});
    e = mq.pop_front();
    p_rgb = e[13:2]; p_hs = e[1]; p_vs = e[0];
    if (d) p_addr = AW'(a);
    p_fs = tik & ~m_ptik;
    m_ptik = tik;
    if (tik) m_eol = 0;
    else if (m_pd && !d) m_eol++;
    m_x = d ? m_x + 1 : 0;
    m_pd = d;
  endtask

  // One cycle: compare outputs of the previous edge, then drive new inputs.
  task automatic step(input logic d, input logic hs, input logic vs, input logic tik);
    @(negedge clock_25);
    if (sn < NOBS) begin
      obs_rgb[sn] = {red, green, blue}; obs_hs[sn] = h_sync_out;
      obs_fs[sn] = frame_start;         obs_addr[sn] = cell_addr;
    end
    chk("rgb", {red, green, blue}, p_rgb);
    chk("h_sync_out", h_sync_out, p_hs);
    chk("v_sync_out", v_sync_out, p_vs);
    chk("cell_addr", cell_addr, p_addr);
    chk("frame_start", frame_start, p_fs);
    display_area = d; h_sync_in = hs; v_sync_in = vs; frame_tik = tik;
    model_cycle(d, hs, vs, tik);
    sn++;
  endtask

  task automatic do_reset(input logic tik);
    @(posedge clock_25); #2;
    reset = 1'b0;
    #1;
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_hsync", h_sync_out, 1);
    chk("rst_vsync", v_sync_out, 1);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_addr", cell_addr, 0);
    display_area = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1; frame_tik = tik;
    repeat (2) @(posedge clock_25);
    #2 reset = 1'b1;
    model_reset();
  endtask

  task automatic line(input int vis, input int blank, input bit rgo);
    for (int i = 0; i < vis; i++) begin
      if (rgo && $urandom_range(0, 63) == 0) game_over = ~game_over;
      step(1'b1, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < blank; i++)
      step(1'b0, !(i >= 1 && i < blank - 1), 1'b1, 1'b0);
  endtask

  task automatic vsync(input int tlen);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (tlen) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, e0, sh, s1, s2, t2, s3, s4, t_rise, nfs;
    for (int i = 0; i < 1024; i++) mem[i] = 2'b00;
    mem[0] = 2'b11; mem[2] = 2'b10; mem[3] = 2'b01; mem[31] = 2'b11; mem[166] = 2'b01;
    model_reset();

    // Reset with frame_tik already high: no pulse after release.
    do_reset(1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("no_fs_after_release", obs_fs[sn-1], 0);

    // Frame 1
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
    t_rise = sn;
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("fs_pulse", obs_fs[t_rise+1], 1);
    chk("fs_one_cycle", obs_fs[t_rise+2], 0);

    s0 = sn;
    for (int i = 0; i < 640; i++) begin
      if (i == 30) game_over = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b0);
    end
    e0 = sn;
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0);
    sh = sn;
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("addr_px0", obs_addr[s0+1], 0);
    chk("addr_px19", obs_addr[s0+20], 0);
    chk("addr_px20", obs_addr[s0+21], 1);
    chk("addr_px639", obs_addr[s0+640], 31);
    chk("addr_hold_blank", obs_addr[e0+3], 31);
    chk("latency_before", obs_rgb[s0+2], 12'h000);
    chk("latency_apple", obs_rgb[s0+3], 12'hF00);
    chk("border_empty", obs_rgb[s0+23], 12'h888);
    chk("head_go_not_latched", obs_rgb[s0+43], 12'h8F8);
    chk("body", obs_rgb[s0+63], 12'h0F0);
    chk("last_px_apple", obs_rgb[e0+2], 12'hF00);
    chk("blank_over_apple", obs_rgb[e0+3], 12'h000);
    chk("hsync_delay_2", obs_hs[sh+2], 1);
    chk("hsync_delay_3", obs_hs[sh+3], 0);

    repeat (19) line(5, 5, 1'b0);
    s1 = sn;
    line(640, 6, 1'b0);
    chk("row1_start_addr", obs_addr[s1+1], 32);
    repeat (79) line(5, 5, 1'b0);
    s2 = sn;
    line(140, 6, 1'b0);
    chk("interior_empty", obs_rgb[s2+103], 12'h000);
    chk("interior_body", obs_rgb[s2+123], 12'h0F0);

    // Frame 2: long tick, game_over now latched.
    t2 = sn;
    repeat (1600) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);
    nfs = 0;
    for (int k = t2 + 1; k < sn; k++) nfs += int'(obs_fs[k]);
    chk("fs_count_long_tik", nfs, 1);
    s3 = sn;
    line(640, 6, 1'b0);
    chk("row_cleared", obs_addr[s3+1], 0);
    chk("go_apple", obs_rgb[s3+3], 12'hF00);
    chk("go_head", obs_rgb[s3+43], 12'hF0F);
    chk("go_body", obs_rgb[s3+63], 12'hF0F);
    s4 = sn;
    line(700, 6, 1'b0);
    chk("col_sat_650", obs_addr[s4+650], 31);
    chk("col_sat_699", obs_addr[s4+700], 31);

    // Mid-line reset with v_sync low so its output visibly returns high.
    vsync(4);
    repeat (30) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(1'b0);
    line(40, 6, 1'b0);

    // Randomized frames; frame 3 is tall enough to saturate row.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 1024; i++) mem[i] = 2'($urandom_range(0, 3));
      game_over = 1'($urandom_range(0, 1));
      vsync($urandom_range(3, 10));
      if (f == 3) begin
        repeat (490) line($urandom_range(1, 6), $urandom_range(2, 4), 1'b1);
      end else begin
        repeat ($urandom_range(5, 40)) line($urandom_range(0, 90), $urandom_range(2, 10), 1'b1);
      end
    end
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
